wb_rr_arbiter: RTL and testbench
================================

Name: wb_rr_arbiter

Overview:
- Round-robin arbiter that shares one classic Wishbone slave port between NUM_MASTERS Wishbone masters.
- Sits between the CPU/DMA-style masters and the shared interconnect or peripheral slave.
- Each grant lasts for the winning master's whole cyc tenure.
- Includes a stalled-transfer watchdog that aborts a strobe the slave never acknowledges.

Parameters:
- NUM_MASTERS, 2, number of requesting masters; legal range 2..8.
- DATA_WIDTH, 32, Wishbone data width.
- ADDR_WIDTH, 32, Wishbone address width.
- GRANULARITY, 8, bits per sel lane; 8, 16 or 32, otherwise $fatal at elaboration/initial.
- TIMEOUT_CYCLES, 256, unacknowledged-strobe cycles before abort; 0 disables the watchdog.

Ports:
- clk_i  in  1  system clock; all logic on its rising edge.
- rst_i  in  1  reset; asynchronous assert, active-low.
- m_adr_i  in  NUM_MASTERS*ADDR_WIDTH  master addresses; master k occupies slice k.
- m_dat_i  in  NUM_MASTERS*DATA_WIDTH  master write data, packed the same way.
- m_we_i  in  NUM_MASTERS  master write enables.
- m_sel_i  in  NUM_MASTERS*(DATA_WIDTH/GRANULARITY)  master byte/lane selects.
- m_stb_i  in  NUM_MASTERS  master strobes.
- m_cyc_i  in  NUM_MASTERS  master cycle requests; a request is m_cyc_i[k]=1.
- m_dat_o  out  DATA_WIDTH  read data, broadcast to all masters.
- m_ack_o  out  NUM_MASTERS  per-master ack.
- s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o  out  widths as above  shared slave request.
- s_dat_i  in  DATA_WIDTH  slave read data.
- s_ack_i  in  1  slave ack.
- grant_o  out  NUM_MASTERS  one-hot registered grant; all zero when idle.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

Behaviour:

Reset values (rst_i low):
- grant_o=0, state=IDLE, last-grant pointer=NUM_MASTERS-1, watchdog counter=0, timeout_o=0.
- Combinationally, s_cyc_o=0, s_stb_o=0 and m_ack_o=0.
- Reset mid-transfer aborts immediately; no ack is returned to any master.

States: IDLE, GRANTED, ABORT.

Arbitration:
- Evaluated in IDLE, or in GRANTED when the granted master's m_cyc_i=0.
- Winner is the first requester found searching from last_grant+1 upward, wrapping modulo NUM_MASTERS.
- Winner is registered into grant_o and last_grant at the next edge; state becomes GRANTED.
- With no requester, go to (or stay in) IDLE with grant_o=0.
- Latency: request seen in cycle N gives s_cyc_o=1 in cycle N+1.
- Handover: the granted master drops cyc in cycle N while another is requesting. The new grant is registered at the edge ending N. s_cyc_o is therefore low for exactly cycle N.
- The master holding the grant cannot be preempted; only cyc deassertion, reset or ABORT changes the grant.

Datapath in GRANTED (g = granted index):
- s_adr_o, s_dat_o, s_we_o and s_sel_o are combinational muxes of master g's slice.
- s_cyc_o = m_cyc_i[g]; s_stb_o = m_stb_i[g] & m_cyc_i[g].
- m_ack_o[g] = s_ack_i; all other m_ack_o bits are 0.
- m_dat_o = s_dat_i.
- In IDLE: s_adr_o, s_dat_o, s_we_o and s_sel_o are 0.

Watchdog (TIMEOUT_CYCLES>0):
- Counter increments each GRANTED cycle with s_stb_o=1 and s_ack_i=0.
- Counter clears on s_ack_i, on a grant change, or when s_stb_o=0.
- On the edge where the count reaches TIMEOUT_CYCLES, enter ABORT for exactly one cycle.

ABORT cycle:
- s_cyc_o=0 and s_stb_o=0.
- m_ack_o[g]=1 and m_dat_o all ones.
- timeout_o=1; the counter clears.
- Next state is GRANTED with the same grant: the master may continue or release.
- Arbitration is not evaluated during ABORT.

Simultaneous events:
- s_ack_i in the same cycle the count would reach the limit: the ack wins and there is no abort.
- Granted cyc dropping in the same cycle an ack arrives: the ack is still forwarded.

Width rules:
- No arithmetic on the datapath.
- Counter width is $clog2(TIMEOUT_CYCLES+1).
- Pointer width is $clog2(NUM_MASTERS).

Test Plan:
1. Reset, then m_cyc_i=2'b01 with a single read, slave returning 0xCAFEBABE with ack one cycle after stb -> grant_o=01 one cycle after the request; m_dat_o=0xCAFEBABE with m_ack_o=01; m_ack_o[1] stays 0.
2. Both masters request continuously with 1-cycle tenures -> grants alternate 01,10,01,10; s_cyc_o low for exactly one cycle between tenures.
3. Master 0 holds cyc for 5 write beats while master 1 requests -> master 1 is not granted until master 0 drops cyc; s_adr_o/s_dat_o track master 0 only during its tenure.
4. TIMEOUT_CYCLES=4, slave never acks -> after 4 stalled cycles there is one ABORT cycle: timeout_o=1, m_ack_o[g]=1, m_dat_o=0xFFFFFFFF, s_cyc_o=0. Then GRANTED resumes with the same grant.
5. TIMEOUT_CYCLES=4, ack on the 4th stalled cycle -> no timeout_o and a normal ack.
6. rst_i low while a transfer is mid-way -> s_cyc_o, grant_o and m_ack_o go to 0 immediately (asynchronous). After release, arbitration starts from master 0.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter
//   Round-robin arbiter that shares one classic Wishbone slave port between
//   NUM_MASTERS Wishbone masters. The grant lasts for the winning master's
//   whole cyc tenure. A watchdog aborts a strobe that the slave never
//   acknowledges.
//
// Ports
//   clk_i      system clock, rising edge
//   rst_i      asynchronous, active-low reset
//   m_*_i      packed master requests; master k occupies slice k
//   m_dat_o    read data, broadcast to all masters
//   m_ack_o    per-master acknowledge
//   s_*_o      shared slave request (muxed from the granted master)
//   s_dat_i    slave read data
//   s_ack_i    slave acknowledge
//   grant_o    one-hot registered grant; all zero when idle
//   timeout_o  one-cycle pulse when the watchdog aborts a transfer
// ---------------------------------------------------------------------------
module wb_rr_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int GRANULARITY    = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]           m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]           m_dat_i,
    input  logic [NUM_MASTERS-1:0]                      m_we_i,
    input  logic [NUM_MASTERS*(DATA_WIDTH/GRANULARITY)-1:0] m_sel_i,
    input  logic [NUM_MASTERS-1:0]                      m_stb_i,
    input  logic [NUM_MASTERS-1:0]                      m_cyc_i,
    output logic [DATA_WIDTH-1:0]                       m_dat_o,
    output logic [NUM_MASTERS-1:0]                      m_ack_o,
    output logic [ADDR_WIDTH-1:0]                       s_adr_o,
    output logic [DATA_WIDTH-1:0]                       s_dat_o,
    output logic                                        s_we_o,
    output logic [DATA_WIDTH/GRANULARITY-1:0]           s_sel_o,
    output logic                                        s_stb_o,
    output logic                                        s_cyc_o,
    input  logic [DATA_WIDTH-1:0]                       s_dat_i,
    input  logic                                        s_ack_i,
    output logic [NUM_MASTERS-1:0]                      grant_o,
    output logic                                        timeout_o
);

    localparam int SEL_W = DATA_WIDTH / GRANULARITY;
    localparam int PTR_W = $clog2(NUM_MASTERS);
    // A zero timeout disables the watchdog; keep a 1-bit counter so the
    // declaration stays legal.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [PTR_W-1:0] LAST_RST = PTR_W'(NUM_MASTERS - 1);
    localparam logic [NUM_MASTERS-1:0] ONE = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

    if (!(GRANULARITY == 8 || GRANULARITY == 16 || GRANULARITY == 32)) begin : g_bad_gran
        $fatal(1, "wb_rr_arbiter: GRANULARITY must be 8, 16 or 32");
    end
    if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_num
        $fatal(1, "wb_rr_arbiter: NUM_MASTERS must be in 2..8");
    end

    typedef enum logic [1:0] {IDLE, GRANTED, ABORT} state_e;

    state_e                 state_q;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [PTR_W-1:0]       last_q;   // also the index of the current grant
    logic [CNT_W-1:0]       cnt_q;

    logic                   win_found;
    logic [PTR_W-1:0]       win_idx;
    logic [PTR_W-1:0]       cand;
    logic                   arbitrate;
    logic                   stall;

    // Search upward from last_q+1, wrapping, so last_q itself is checked last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = PTR_W'((int'(last_q) + i) % NUM_MASTERS);
            if (!win_found && m_cyc_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign arbitrate = (state_q == IDLE) || ((state_q == GRANTED) && !m_cyc_i[last_q]);
    assign stall     = (state_q == GRANTED) && s_stb_o && !s_ack_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE, GRANTED: begin
                    if (arbitrate) begin
                        cnt_q <= '0;
                        if (win_found) begin
                            state_q <= GRANTED;
                            grant_q <= ONE << win_idx;
                            last_q  <= win_idx;
                        end else begin
                            state_q <= IDLE;
                            grant_q <= '0;
                        end
                    end else if (TIMEOUT_CYCLES > 0 && stall) begin
                        // An ack in this cycle makes stall false, so the ack
                        // always beats a coincident timeout.
                        if (cnt_q == CNT_LAST) begin
                            state_q <= ABORT;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
                ABORT: begin
                    // Grant is kept; the master decides whether to retry or release.
                    state_q <= GRANTED;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        m_ack_o = '0;
        m_dat_o = s_dat_i;
        if (state_q != IDLE) begin
            s_adr_o = m_adr_i[int'(last_q)*ADDR_WIDTH +: ADDR_WIDTH];
            s_dat_o = m_dat_i[int'(last_q)*DATA_WIDTH +: DATA_WIDTH];
            s_we_o  = m_we_i[last_q];
            s_sel_o = m_sel_i[int'(last_q)*SEL_W +: SEL_W];
        end
        if (state_q == GRANTED) begin
            s_cyc_o          = m_cyc_i[last_q];
            s_stb_o          = m_stb_i[last_q] & m_cyc_i[last_q];
            // Forwarded even if cyc drops in the same cycle.
            m_ack_o[last_q]  = s_ack_i;
        end else if (state_q == ABORT) begin
            m_ack_o[last_q]  = 1'b1;
            m_dat_o          = '1;
        end
    end

    assign grant_o   = grant_q;
    assign timeout_o = (state_q == ABORT);

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] m_adr;
    logic [63:0] m_dat;
    logic [1:0]  m_we;
    logic [7:0]  m_sel;
    logic [1:0]  m_stb;
    logic [1:0]  m_cyc;
    logic [31:0] s_dat;
    logic        s_ack;

    logic [31:0] m_dat_o;
    logic [1:0]  m_ack_o;
    logic [31:0] s_adr_o;
    logic [31:0] s_dat_o;
    logic        s_we_o;
    logic [3:0]  s_sel_o;
    logic        s_stb_o;
    logic        s_cyc_o;
    logic [1:0]  grant_o;
    logic        timeout_o;

    int tests = 0;
    int fails = 0;

    wb_rr_arbiter #(
        .NUM_MASTERS(2), .DATA_WIDTH(32), .ADDR_WIDTH(32),
        .GRANULARITY(8), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i(clk), .rst_i(rst_n),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_we_i(m_we), .m_sel_i(m_sel),
        .m_stb_i(m_stb), .m_cyc_i(m_cyc),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
        .s_dat_i(s_dat), .s_ack_i(s_ack),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 ns later.
    task automatic step(input logic [1:0] cyc, input logic [1:0] stb, input logic ack);
        @(negedge clk);
        m_cyc = cyc;
        m_stb = stb;
        s_ack = ack;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n = 1'b0;
        m_adr = '0; m_dat = '0; m_we = '0; m_sel = '0;
        m_stb = '0; m_cyc = '0; s_dat = '0; s_ack = 1'b0;

        // Reset: outputs stay quiet even with requests and an ack present
        repeat (2) @(negedge clk);
        m_cyc = 2'b11; m_stb = 2'b11; s_ack = 1'b1; #1;
        check("rst_grant",   32'(grant_o),   32'h0);
        check("rst_s_cyc",   32'(s_cyc_o),   32'h0);
        check("rst_s_stb",   32'(s_stb_o),   32'h0);
        check("rst_m_ack",   32'(m_ack_o),   32'h0);
        check("rst_timeout", 32'(timeout_o), 32'h0);
        @(negedge clk);
        m_cyc = '0; m_stb = '0; s_ack = 1'b0; rst_n = 1'b1; #1;
        check("idle_grant", 32'(grant_o), 32'h0);

        // Test 1: single read by master 0
        m_adr[31:0] = 32'h0000_1000; m_we = 2'b00; m_sel = 8'hFF;
        step(2'b01, 2'b01, 1'b0);
        check("t1_req_grant", 32'(grant_o), 32'h0);
        check("t1_req_s_cyc", 32'(s_cyc_o), 32'h0);
        step(2'b01, 2'b01, 1'b0);
        check("t1_grant",  32'(grant_o), 32'h1);
        check("t1_s_cyc",  32'(s_cyc_o), 32'h1);
        check("t1_s_stb",  32'(s_stb_o), 32'h1);
        check("t1_s_adr",  s_adr_o,      32'h0000_1000);
        check("t1_s_sel",  32'(s_sel_o), 32'hF);
        check("t1_no_ack", 32'(m_ack_o), 32'h0);
        s_dat = 32'hCAFE_BABE;
        step(2'b01, 2'b01, 1'b1);
        check("t1_m_ack", 32'(m_ack_o), 32'h1);
        check("t1_m_dat", m_dat_o,      32'hCAFE_BABE);
        step(2'b00, 2'b00, 1'b0);
        check("t1_rel_ack",   32'(m_ack_o), 32'h0);
        check("t1_rel_s_cyc", 32'(s_cyc_o), 32'h0);
        step(2'b00, 2'b00, 1'b0);
        check("t1_idle_grant", 32'(grant_o), 32'h0);
        check("t1_idle_adr",   s_adr_o,      32'h0);

        // Test 2: both masters request, 1-cycle tenures (last grant was 0)
        m_adr = {32'h0000_B000, 32'h0000_A000};
        step(2'b11, 2'b11, 1'b0);
        check("t2_c1_grant", 32'(grant_o), 32'h0);
        step(2'b11, 2'b11, 1'b1);
        check("t2_c2_grant", 32'(grant_o), 32'h2);
        check("t2_c2_s_cyc", 32'(s_cyc_o), 32'h1);
        check("t2_c2_m_ack", 32'(m_ack_o), 32'h2);
        check("t2_c2_s_adr", s_adr_o,      32'h0000_B000);
        step(2'b01, 2'b01, 1'b0);
        check("t2_c3_grant", 32'(grant_o), 32'h2);
        check("t2_c3_s_cyc", 32'(s_cyc_o), 32'h0);
        step(2'b11, 2'b11, 1'b1);
        check("t2_c4_grant", 32'(grant_o), 32'h1);
        check("t2_c4_s_cyc", 32'(s_cyc_o), 32'h1);
        check("t2_c4_m_ack", 32'(m_ack_o), 32'h1);
        check("t2_c4_s_adr", s_adr_o,      32'h0000_A000);
        step(2'b10, 2'b10, 1'b0);
        check("t2_c5_s_cyc", 32'(s_cyc_o), 32'h0);
        step(2'b11, 2'b11, 1'b1);
        check("t2_c6_grant", 32'(grant_o), 32'h2);
        check("t2_c6_m_ack", 32'(m_ack_o), 32'h2);
        step(2'b01, 2'b01, 1'b0);
        check("t2_c7_s_cyc", 32'(s_cyc_o), 32'h0);
        step(2'b01, 2'b01, 1'b1);
        check("t2_c8_grant", 32'(grant_o), 32'h1);
        check("t2_c8_m_ack", 32'(m_ack_o), 32'h1);
        step(2'b00, 2'b00, 1'b0);

        // Test 3: master 0 holds 5 write beats while master 1 waits
        m_we = 2'b01;
        m_adr[63:32] = 32'h0000_3000;
        m_dat[63:32] = 32'h0000_0055;
        step(2'b01, 2'b01, 1'b0);
        check("t3_req_grant", 32'(grant_o), 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            m_adr[31:0] = 32'h0000_2000 + 32'(i * 4);
            m_dat[31:0] = 32'h1000_0000 + 32'(i);
            m_cyc = 2'b11; m_stb = 2'b11; s_ack = 1'b1;
            #1;
            check($sformatf("t3_b%0d_grant", i), 32'(grant_o), 32'h1);
            check($sformatf("t3_b%0d_s_adr", i), s_adr_o, 32'h0000_2000 + 32'(i * 4));
            check($sformatf("t3_b%0d_s_dat", i), s_dat_o, 32'h1000_0000 + 32'(i));
            check($sformatf("t3_b%0d_s_we", i),  32'(s_we_o),  32'h1);
            check($sformatf("t3_b%0d_m_ack", i), 32'(m_ack_o), 32'h1);
        end
        step(2'b10, 2'b10, 1'b0);
        check("t3_rel_grant", 32'(grant_o), 32'h1);
        check("t3_rel_s_cyc", 32'(s_cyc_o), 32'h0);
        step(2'b10, 2'b10, 1'b1);
        check("t3_m1_grant", 32'(grant_o), 32'h2);
        check("t3_m1_s_adr", s_adr_o,      32'h0000_3000);
        check("t3_m1_s_dat", s_dat_o,      32'h0000_0055);
        check("t3_m1_s_we",  32'(s_we_o),  32'h0);
        check("t3_m1_m_ack", 32'(m_ack_o), 32'h2);
        step(2'b00, 2'b00, 1'b0);

        // Test 4: slave never acks, watchdog fires after 4 stalled cycles
        m_we = 2'b00;
        m_adr[31:0] = 32'h0000_5000;
        step(2'b01, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(2'b01, 2'b01, 1'b0);
            check($sformatf("t4_s%0d_grant", i),   32'(grant_o),   32'h1);
            check($sformatf("t4_s%0d_timeout", i), 32'(timeout_o), 32'h0);
            check($sformatf("t4_s%0d_s_cyc", i),   32'(s_cyc_o),   32'h1);
            check($sformatf("t4_s%0d_m_ack", i),   32'(m_ack_o),   32'h0);
        end
        s_dat = 32'h1234_5678;
        step(2'b01, 2'b01, 1'b0);
        check("t4_ab_timeout", 32'(timeout_o), 32'h1);
        check("t4_ab_m_ack",   32'(m_ack_o),   32'h1);
        check("t4_ab_m_dat",   m_dat_o,        32'hFFFF_FFFF);
        check("t4_ab_s_cyc",   32'(s_cyc_o),   32'h0);
        check("t4_ab_s_stb",   32'(s_stb_o),   32'h0);
        check("t4_ab_grant",   32'(grant_o),   32'h1);
        step(2'b01, 2'b01, 1'b0);
        check("t4_re_grant",   32'(grant_o),   32'h1);
        check("t4_re_timeout", 32'(timeout_o), 32'h0);
        check("t4_re_s_cyc",   32'(s_cyc_o),   32'h1);
        check("t4_re_m_dat",   m_dat_o,        32'h1234_5678);
        step(2'b00, 2'b00, 1'b0);

        // Test 5: ack on the 4th stalled cycle wins over the watchdog
        m_adr[63:32] = 32'h0000_6000;
        step(2'b10, 2'b10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(2'b10, 2'b10, 1'b0);
            check($sformatf("t5_s%0d_grant", i),   32'(grant_o),   32'h2);
            check($sformatf("t5_s%0d_timeout", i), 32'(timeout_o), 32'h0);
        end
        s_dat = 32'hA5A5_A5A5;
        step(2'b10, 2'b10, 1'b1);
        check("t5_ack_m_ack",   32'(m_ack_o),   32'h2);
        check("t5_ack_m_dat",   m_dat_o,        32'hA5A5_A5A5);
        check("t5_ack_timeout", 32'(timeout_o), 32'h0);
        step(2'b00, 2'b00, 1'b0);
        check("t5_rel_timeout", 32'(timeout_o), 32'h0);
        check("t5_rel_grant",   32'(grant_o),   32'h2);
        check("t5_rel_m_ack",   32'(m_ack_o),   32'h0);
        step(2'b00, 2'b00, 1'b0);
        check("t5_idle_grant",   32'(grant_o),   32'h0);
        check("t5_idle_timeout", 32'(timeout_o), 32'h0);

        // Test 6: asynchronous reset mid-transfer, then arbitration from master 0
        m_adr = {32'h0000_3000, 32'h0000_4000};
        step(2'b01, 2'b01, 1'b0);
        step(2'b01, 2'b01, 1'b1);
        check("t6_pre_grant", 32'(grant_o), 32'h1);
        check("t6_pre_m_ack", 32'(m_ack_o), 32'h1);
        check("t6_pre_s_cyc", 32'(s_cyc_o), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_s_cyc", 32'(s_cyc_o), 32'h0);
        check("t6_rst_s_stb", 32'(s_stb_o), 32'h0);
        check("t6_rst_grant", 32'(grant_o), 32'h0);
        check("t6_rst_m_ack", 32'(m_ack_o), 32'h0);
        @(negedge clk);
        m_cyc = 2'b11; m_stb = 2'b11; s_ack = 1'b0; rst_n = 1'b1;
        #1;
        check("t6_rel_grant", 32'(grant_o), 32'h0);
        step(2'b11, 2'b11, 1'b0);
        check("t6_first_grant", 32'(grant_o), 32'h1);
        check("t6_first_s_adr", s_adr_o,      32'h0000_4000);
        step(2'b00, 2'b00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
